// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: NOP encoding, entry layout
// and pointer-width helpers.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Entry layout at the default widths; the queue packs entries as {pc, instr, misaligned}.
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int entry_w(input int addr_bits, input int data_width);
        return addr_bits + data_width + 1;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module fq_storage #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_ptr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_ptr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: in-order {PC, instr} buffer
// with valid/ready on both sides, first-word-fall-through head, redirect flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [ADDRESS_BITS-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0]   in_instr,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [ADDRESS_BITS-1:0] out_pc,
    output logic [DATA_WIDTH-1:0]   out_instr,
    output logic                    out_misaligned,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W   = ptr_w(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_w(ADDRESS_BITS, DATA_WIDTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;

    // in_ready looks only at occupancy, never at out_ready: a full queue refuses
    // a push even in a cycle where decode is popping.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_wr_entry = {in_pc, in_instr, |in_pc[1:0]};

    fq_storage #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clock     (clock),
        .i_wr_en   (w_push),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // Reset and flush both discard any push/pop presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty queue presents a NOP at PC 0 instead of stale storage.
    always_comb begin
        out_pc         = '0;
        out_instr      = DATA_WIDTH'(NOP_INSTR);
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = w_rd_entry[ENTRY_W-1 -: ADDRESS_BITS];
            out_instr      = w_rd_entry[DATA_WIDTH:1];
            out_misaligned = w_rd_entry[0];
        end
    end

    assign count = r_count;

endmodule
